// File: rtl/encoder16x4_seq.sv
// encoder16x4_seq
// Sequential 16-line-to-4-bit priority encoder. Request pulses on the 16
// input lines are latched into a pending register, and their indices are
// then handed out one at a time over a valid/ready handshake. The code
// output can drive a 4x16 decoder directly to regenerate the line.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   en      sample enable; when low, req is ignored and pending drains
//   req     16 request lines; bit i high at an edge requests code i
//   ready   consumer accepts the presented code this cycle
//   code    index of the granted line (registered)
//   valid   code is meaningful (registered)
//   pending current pending register (registered)
//   merged  one-cycle pulse: an incoming req bit hit an already-pending bit
//
// Configuration macro:
//   ENC_ROUND_ROBIN_EN  when defined, priority rotates. After granting
//                       index i the next search starts at i-1 and descends
//                       with wrap. When undefined, index 15 always has the
//                       highest priority.

module encoder16x4_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        ready,
  output logic [3:0]  code,
  output logic        valid,
  output logic [15:0] pending,
  output logic        merged
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  search_start;
  logic [3:0]  sel_idx;
  logic        sel_found;
  logic        load;
  logic [15:0] req_in;
  logic [15:0] grant_mask;
  logic [15:0] pending_d;
  logic [3:0]  code_d;
  logic        valid_d;
  logic        merged_d;

`ifdef ENC_ROUND_ROBIN_EN
  // Index of the most recent grant. Resetting to 0 makes the first
  // search begin at 15, matching the fixed-priority order until the
  // first grant rotates it.
  logic [3:0] last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 4'd0;
    end else if (load) begin
      last_q <= sel_idx;
    end
  end

  assign search_start = last_q - 4'd1;
`else
  assign search_start = 4'd15;
`endif

  // Descending search over the registered pending vector starting at
  // search_start. Requests arriving at this edge are not yet in pending,
  // so they cannot be selected until the following edge.
  always_comb begin
    logic [3:0] idx;
    idx       = 4'd0;
    sel_idx   = 4'd0;
    sel_found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = search_start - 4'(k);
      if (!sel_found && pending[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  // State register plus the registered outputs and pending vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pending <= 16'h0000;
      code    <= 4'd0;
      valid   <= 1'b0;
      merged  <= 1'b0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
      code    <= code_d;
      valid   <= valid_d;
      merged  <= merged_d;
    end
  end

  // Next-state logic. A new index is loaded whenever the output slot is
  // free (IDLE) or being emptied by an accepted transfer, and something
  // is pending. sel_found is equivalent to pending != 0.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          if (sel_found) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. The grant clear is applied before the
  // new requests are OR-ed in, so a same-edge re-request of the granted
  // bit survives. That bit is no longer in (pending & ~grant_mask), so it
  // does not count as a merge.
  always_comb begin
    req_in     = en ? req : 16'h0000;
    grant_mask = load ? (16'h0001 << sel_idx) : 16'h0000;
    pending_d  = (pending & ~grant_mask) | req_in;
    merged_d   = |(pending & ~grant_mask & req_in);
    code_d     = load ? sel_idx : code;
    valid_d    = (state_d == HOLD);
  end

endmodule
